mem_bus_ctrl: RTL and testbench
===============================

// Module: mem_bus_ctrl
// PURPOSE
//  Responder for the hart's instruction and data cache-line buses. Arbitrates
//  line reads (L1i, L1d) and line writes (L1d) onto one narrow external memory
//  port, split into BEAT_W-bit beats. Reassembles read lines and pulses b_dv_i/b_dv.
//  Sits between hart and the SoC memory/L2 side.
// PARAMETERS
//  LINE_W   1024  cache line width, bits
//  BEAT_W   64    external beat width, bits; LINE_W % BEAT_W == 0
//  BEATS    LINE_W/BEAT_W (derived, 16)  beats per line
// PORTS
//  clk         in   1       clock, all state on posedge
//  rst_n       in   1       asynchronous active-low reset
//  b_addr_i    in   64      I-line address, [6:0]==0
//  b_rd_i      in   1       I-line read request, level, held until b_dv_i
//  b_data_i    out  LINE_W  I-line data, valid while b_dv_i=1
//  b_dv_i      out  1       I-line done, 1-cycle pulse
//  b_addr      in   64      D-line address, [6:0]==0
//  b_rd        in   1       D-line read request, level
//  b_wr        in   1       D-line write request, level
//  b_data_out  in   LINE_W  D-line write data, held with b_wr
//  b_data_in   out  LINE_W  D-line read data, valid while b_dv=1
//  b_dv        out  1       D-line done (read or write), 1-cycle pulse
//  m_req       out  1       external beat request
//  m_we        out  1       1=write beat, 0=read beat
//  m_addr      out  64      beat byte address
//  m_wdata     out  BEAT_W  write beat data
//  m_ack       in   1       beat accepted; read data valid same cycle
//  m_rdata     in   BEAT_W  read beat data
// BEHAVIOUR
//  - Reset (async): FSM=IDLE, beat cnt=0, line reg=0, rr ptr=I-side next,
//    m_req=0, m_we=0, m_addr=0, m_wdata=0, b_dv_i=0, b_dv=0.
//  - FSM: IDLE -> XFER -> DONE -> IDLE. Requests are sampled only in IDLE.
//  - IDLE: pending set = {I: b_rd_i, D: b_rd|b_wr}. If one pending, grant it.
//    If both pending, round-robin: grant the side not granted last. Latch the
//    side, line address and op (D: b_wr has priority over b_rd if both high).
//    For a write, latch b_data_out. Go to XFER.
//  - XFER: m_req=1; m_addr = line_addr + cnt*(BEAT_W/8); m_we=op.
//    m_wdata = wline[cnt*BEAT_W +: BEAT_W]. On m_req&&m_ack, a read stores
//    m_rdata into line[cnt*BEAT_W +: BEAT_W] and cnt increments.
//    Ack on cnt==BEATS-1: cnt wraps to 0 and the FSM goes to DONE.
//    m_ack low: hold all outputs, no timeout.
//  - DONE: one cycle. b_dv_i=1 (I grant) or b_dv=1 (D grant); m_req=0.
//    b_data_i and b_data_in both drive the line reg. Data is only meaningful
//    with its dv. Requester must drop rd/wr on the edge where dv=1.
//  - Latency, m_ack tied high: request high in IDLE cycle 0. Beats go out
//    cycles 1..BEATS. dv is high in cycle BEATS+1 (17). The next grant can
//    start at cycle BEATS+2.
//  - Request dropped mid-transfer: the transfer still completes and dv still
//    pulses (abort not supported).
//  - Address bits [6:0] are ignored (forced 0).
//  - rst_n low mid-transfer: immediate IDLE, m_req drops asynchronously,
//    partial line discarded, no dv.
//  - b_dv_i and b_dv are never high in the same cycle.
// STRUCTURE
//  - Package rv6_bus_pkg: LINE_W/BEAT_W defaults, FSM state enum
//    {S_IDLE,S_XFER,S_DONE}, grant enum {G_I,G_D}, op enum {OP_RD,OP_WR}.
//  - One sub-module: bus_rr_arb, a 2-way round-robin arbiter with req[1:0],
//    en (=IDLE), gnt[1:0] one-hot and an internal last-grant flop.
//  - The top holds the FSM, beat counter, line register and write line register.
// TESTING
//  1 I-read, m_ack=1, m_rdata=0x1000+beat -> b_dv_i at cycle 17;
//    b_data_i[k*64+:64]=0x1000+k; m_addr steps 0x80,0x88..0xF8.
//  2 D-write b_addr=0x200, b_data_out=pattern -> 16 beats m_we=1, m_wdata
//    matches slices, b_dv pulses once, b_dv_i stays 0.
//  3 b_rd_i and b_rd both high from reset -> I served first, then D.
//    Re-raise both -> D first, then I (round-robin alternation).
//  4 m_ack random ~50% -> line identical to test 1; m_addr and m_wdata
//    stable while ack=0.
//  5 rst_n low at beat 7 of a read -> m_req=0 immediately, no dv. After
//    reset, a new request completes normally.
//  6 b_rd and b_wr both high -> write performed, b_dv once; b_rd_i
//    dropped mid-transfer -> b_dv_i still pulses.

Source files
------------

// File: rtl/rv6_bus_pkg.sv
// rv6_bus_pkg: shared widths and enums for the hart cache-line bus controller
package rv6_bus_pkg;
  localparam int DEF_LINE_W = 1024;
  localparam int DEF_BEAT_W = 64;
  typedef enum logic [1:0] {S_IDLE, S_XFER, S_DONE} state_e;
  typedef enum logic {G_I, G_D} grant_e;
  typedef enum logic {OP_RD, OP_WR} op_e;
endpackage

// File: rtl/bus_rr_arb.sv
// bus_rr_arb: 2-way round-robin arbiter, req[0]=I side, req[1]=D side
module bus_rr_arb
  import rv6_bus_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);
  grant_e last;
  always_comb gnt = !en ? 2'b00 : (req == 2'b11) ? ((last == G_I) ? 2'b10 : 2'b01) : req;
  // the pointer only advances on contention, so an uncontended grant never costs the other side its turn
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last <= G_D;
    else if (en && req == 2'b11) last <= gnt[1] ? G_D : G_I;
  end
endmodule

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: arbitrates I/D cache-line reads and D-line writes onto one beat-wide memory port
module mem_bus_ctrl
  import rv6_bus_pkg::*;
#(
  parameter int LINE_W = DEF_LINE_W,
  parameter int BEAT_W = DEF_BEAT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [63:0]       b_addr_i,
  input  logic              b_rd_i,
  output logic [LINE_W-1:0] b_data_i,
  output logic              b_dv_i,
  input  logic [63:0]       b_addr,
  input  logic              b_rd,
  input  logic              b_wr,
  input  logic [LINE_W-1:0] b_data_out,
  output logic [LINE_W-1:0] b_data_in,
  output logic              b_dv,
  output logic              m_req,
  output logic              m_we,
  output logic [63:0]       m_addr,
  output logic [BEAT_W-1:0] m_wdata,
  input  logic              m_ack,
  input  logic [BEAT_W-1:0] m_rdata
);
  localparam int BEATS = LINE_W / BEAT_W;
  localparam int CW = $clog2(BEATS);
  localparam logic [63:0] ALIGN = ~64'(LINE_W / 8 - 1);
  state_e state;
  grant_e side;
  op_e op;
  logic [CW-1:0] cnt;
  logic [LINE_W-1:0] line, wline;
  logic [1:0] gnt;
  bus_rr_arb u_arb (.clk, .rst_n, .req({b_rd | b_wr, b_rd_i}), .en(state == S_IDLE), .gnt);
  assign b_data_i = line;
  assign b_data_in = line;
  // both line registers shift one beat per ack, so the current beat always sits at the low/high end
  assign m_wdata = wline[BEAT_W-1:0];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      side <= G_I;
      op <= OP_RD;
      cnt <= '0;
      line <= '0;
      wline <= '0;
      m_req <= 1'b0;
      m_we <= 1'b0;
      m_addr <= '0;
      b_dv_i <= 1'b0;
      b_dv <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (|gnt) begin
          side <= gnt[1] ? G_D : G_I;
          op <= (gnt[1] && b_wr) ? OP_WR : OP_RD;
          m_we <= gnt[1] && b_wr;
          m_addr <= (gnt[1] ? b_addr : b_addr_i) & ALIGN;
          wline <= (gnt[1] && b_wr) ? b_data_out : '0;
          cnt <= '0;
          m_req <= 1'b1;
          state <= S_XFER;
        end
        S_XFER: if (m_ack) begin
          if (op == OP_RD) line <= {m_rdata, line[LINE_W-1:BEAT_W]};
          wline <= wline >> BEAT_W;
          m_addr <= m_addr + 64'(BEAT_W / 8);
          cnt <= (cnt == CW'(BEATS - 1)) ? '0 : cnt + 1'b1;
          if (cnt == CW'(BEATS - 1)) begin
            m_req <= 1'b0;
            m_we <= 1'b0;
            b_dv_i <= side == G_I;
            b_dv <= side == G_D;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          b_dv_i <= 1'b0;
          b_dv <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb_mem_bus_ctrl: randomized self-checking bench for mem_bus_ctrl against a line/beat arithmetic model
module tb_mem_bus_ctrl;
  localparam int LINE_W = 1024;
  localparam int BEATS = 16;
  logic clk, rst_n;
  logic [63:0] b_addr_i, b_addr, m_addr, m_wdata, m_rdata;
  logic b_rd_i, b_dv_i, b_rd, b_wr, b_dv, m_req, m_we, m_ack;
  logic [LINE_W-1:0] b_data_i, b_data_out, b_data_in;
  int n_chk, n_fail;
  int cyc, beats, dvi_n, dv_n, both_n, stab_err, dvi_cyc, dv_cyc;
  logic [LINE_W-1:0] cap_i, cap_d;
  logic [63:0] q_addr[$], q_wd[$];
  bit q_we[$];
  int order[$];
  bit hold;
  logic [63:0] h_addr, h_wd;
  logic h_we;

  mem_bus_ctrl dut (.clk(clk), .rst_n(rst_n), .b_addr_i(b_addr_i), .b_rd_i(b_rd_i), .b_data_i(b_data_i),
    .b_dv_i(b_dv_i), .b_addr(b_addr), .b_rd(b_rd), .b_wr(b_wr), .b_data_out(b_data_out),
    .b_data_in(b_data_in), .b_dv(b_dv), .m_req(m_req), .m_we(m_we), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_ack(m_ack), .m_rdata(m_rdata));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clr_mon;
    cyc = 0; beats = 0; dvi_n = 0; dv_n = 0; both_n = 0; stab_err = 0;
    dvi_cyc = -1; dv_cyc = -1; hold = 0;
    q_addr.delete(); q_wd.delete(); q_we.delete(); order.delete();
  endtask

  task automatic reset_dut;
    rst_n = 1'b0; b_rd_i = 0; b_rd = 0; b_wr = 0; m_ack = 0; m_rdata = '0;
    b_addr_i = '0; b_addr = '0; b_data_out = '0;
    repeat (3) tick;
    rst_n = 1'b1;
    tick;
  endtask

  // memory-side responder: acks with probability ack_pct, returns rbase+beat, records every accepted beat
  task automatic serve(input int ack_pct, input logic [63:0] rbase, input int n_dv, input int stop_beats, input int max_cyc);
    bit ack;
    for (int k = 0; k < max_cyc; k++) begin
      if (b_dv_i) begin dvi_n++; dvi_cyc = cyc; cap_i = b_data_i; order.push_back(0); b_rd_i = 0; end
      if (b_dv) begin dv_n++; dv_cyc = cyc; cap_d = b_data_in; order.push_back(1); b_rd = 0; b_wr = 0; end
      if (b_dv && b_dv_i) both_n++;
      if (hold && m_req && (m_addr !== h_addr || m_wdata !== h_wd || m_we !== h_we)) stab_err++;
      if (dvi_n + dv_n >= n_dv || (stop_beats > 0 && beats == stop_beats)) begin m_ack = 0; return; end
      ack = $urandom_range(99) < ack_pct;
      m_ack = ack;
      m_rdata = rbase + 64'(beats);
      if (m_req && ack) begin q_addr.push_back(m_addr); q_wd.push_back(m_wdata); q_we.push_back(m_we); beats++; end
      hold = m_req && !ack; h_addr = m_addr; h_wd = m_wdata; h_we = m_we;
      tick;
      cyc++;
    end
    m_ack = 0;
    n_chk++; n_fail++;
    $display("FAIL serve_timeout: got %0d dv after %0d cycles, need %0d", dvi_n + dv_n, max_cyc, n_dv);
  endtask

  task automatic drain(input int n);
    m_ack = 0;
    for (int k = 0; k < n; k++) begin
      tick;
      cyc++;
      if (b_dv_i) dvi_n++;
      if (b_dv) dv_n++;
      if (b_dv_i && b_dv) both_n++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; b_rd_i = 1; b_rd = 1; b_wr = 0; m_ack = 1; m_rdata = 64'hdead;
    b_addr_i = 64'h80; b_addr = 64'h100; b_data_out = '1;
    repeat (2) tick;
    n_chk++; if ({m_req, m_we, b_dv, b_dv_i} !== 4'b0) begin n_fail++; $display("FAIL reset_ctrl: got %b want 0000", {m_req, m_we, b_dv, b_dv_i}); end
    n_chk++; if (m_addr !== 64'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", m_addr); end
    n_chk++; if (m_wdata !== 64'h0) begin n_fail++; $display("FAIL reset_wdata: got %h want 0", m_wdata); end
    n_chk++; if (b_data_i !== '0 || b_data_in !== '0) begin n_fail++; $display("FAIL reset_line: got %h want 0", b_data_i[63:0]); end
    reset_dut;
  endtask

  task automatic check_read_line(input string nm, input logic [LINE_W-1:0] got, input logic [63:0] base);
    for (int k = 0; k < BEATS; k++) begin
      n_chk++;
      if (got[k*64 +: 64] !== base + 64'(k)) begin n_fail++; $display("FAIL %s beat %0d: got %h want %h", nm, k, got[k*64 +: 64], base + 64'(k)); end
    end
  endtask

  task automatic check_addrs(input string nm, input logic [63:0] line_addr, input int first);
    for (int k = 0; k < BEATS && first + k < q_addr.size(); k++) begin
      n_chk++;
      if (q_addr[first + k] !== line_addr + 64'(8 * k)) begin n_fail++; $display("FAIL %s addr %0d: got %h want %h", nm, k, q_addr[first + k], line_addr + 64'(8 * k)); end
    end
  endtask

  task automatic test_i_read;
    clr_mon;
    b_addr_i = 64'h80; b_rd_i = 1;
    serve(100, 64'h1000, 1, 0, 100);
    n_chk++; if (dvi_cyc !== 17) begin n_fail++; $display("FAIL iread_latency: got %0d want 17", dvi_cyc); end
    n_chk++; if (m_req !== 1'b0) begin n_fail++; $display("FAIL iread_req_at_dv: got %b want 0", m_req); end
    check_read_line("iread_data", cap_i, 64'h1000);
    n_chk++; if (q_addr.size() !== BEATS) begin n_fail++; $display("FAIL iread_beats: got %0d want %0d", q_addr.size(), BEATS); end
    check_addrs("iread", 64'h80, 0);
    drain(4);
    n_chk++; if (dvi_n !== 1 || dv_n !== 0) begin n_fail++; $display("FAIL iread_dv_count: got i=%0d d=%0d want i=1 d=0", dvi_n, dv_n); end
  endtask

  task automatic test_d_write(input bit also_rd, input int ack_pct);
    logic [LINE_W-1:0] pat;
    for (int k = 0; k < LINE_W / 32; k++) pat[k*32 +: 32] = $urandom;
    clr_mon;
    b_addr = 64'h200; b_data_out = pat; b_wr = 1; b_rd = also_rd;
    serve(ack_pct, 64'hbad0, 1, 0, 400);
    drain(4);
    n_chk++; if (q_wd.size() !== BEATS) begin n_fail++; $display("FAIL dwrite_beats: got %0d want %0d", q_wd.size(), BEATS); end
    for (int k = 0; k < BEATS && k < q_wd.size(); k++) begin
      n_chk++; if (q_we[k] !== 1'b1) begin n_fail++; $display("FAIL dwrite_we %0d: got %b want 1", k, q_we[k]); end
      n_chk++; if (q_wd[k] !== pat[k*64 +: 64]) begin n_fail++; $display("FAIL dwrite_wdata %0d: got %h want %h", k, q_wd[k], pat[k*64 +: 64]); end
    end
    check_addrs("dwrite", 64'h200, 0);
    n_chk++; if (dv_n !== 1 || dvi_n !== 0) begin n_fail++; $display("FAIL dwrite_dv_count: got d=%0d i=%0d want d=1 i=0", dv_n, dvi_n); end
    n_chk++; if (dv_cyc !== 17 && ack_pct == 100) begin n_fail++; $display("FAIL dwrite_latency: got %0d want 17", dv_cyc); end
    n_chk++; if (stab_err !== 0) begin n_fail++; $display("FAIL dwrite_stable: got %0d changes want 0", stab_err); end
  endtask

  task automatic test_round_robin;
    reset_dut;
    clr_mon;
    b_addr_i = 64'h1000; b_addr = 64'h2000; b_rd_i = 1; b_rd = 1;
    serve(100, 64'h3000, 2, 0, 200);
    n_chk++; if (order.size() != 2 || order[0] != 0 || order[1] != 1) begin n_fail++; $display("FAIL rr1_order: got %p want '{0,1}", order); end
    n_chk++; if (dvi_cyc !== 17 || dv_cyc !== 35) begin n_fail++; $display("FAIL rr1_cycles: got i=%0d d=%0d want i=17 d=35", dvi_cyc, dv_cyc); end
    check_addrs("rr1_i", 64'h1000, 0);
    check_addrs("rr1_d", 64'h2000, BEATS);
    check_read_line("rr1_d_data", cap_d, 64'h3000 + 64'(BEATS));
    drain(2);
    clr_mon;
    b_rd_i = 1; b_rd = 1;
    serve(100, 64'h4000, 2, 0, 200);
    n_chk++; if (order.size() != 2 || order[0] != 1 || order[1] != 0) begin n_fail++; $display("FAIL rr2_order: got %p want '{1,0}", order); end
    n_chk++; if (dv_cyc !== 17 || dvi_cyc !== 35) begin n_fail++; $display("FAIL rr2_cycles: got d=%0d i=%0d want d=17 i=35", dv_cyc, dvi_cyc); end
    n_chk++; if (both_n !== 0) begin n_fail++; $display("FAIL rr_dv_overlap: got %0d want 0", both_n); end
    drain(3);
  endtask

  task automatic test_random_ack;
    clr_mon;
    b_addr_i = 64'h80 | 64'h5b; b_rd_i = 1;
    serve(50, 64'h1000, 1, 0, 2000);
    check_read_line("rack_data", cap_i, 64'h1000);
    check_addrs("rack", 64'h80, 0);
    n_chk++; if (stab_err !== 0) begin n_fail++; $display("FAIL rack_stable: got %0d changes want 0", stab_err); end
    drain(4);
    n_chk++; if (dvi_n !== 1 || dv_n !== 0) begin n_fail++; $display("FAIL rack_dv_count: got i=%0d d=%0d want i=1 d=0", dvi_n, dv_n); end
  endtask

  task automatic test_reset_mid;
    clr_mon;
    b_addr_i = 64'h400; b_rd_i = 1;
    serve(100, 64'h5000, 1, 7, 100);
    n_chk++; if (beats !== 7 || m_req !== 1'b1) begin n_fail++; $display("FAIL rmid_before: got beats=%0d req=%b want 7/1", beats, m_req); end
    rst_n = 1'b0;
    #1;
    n_chk++; if (m_req !== 1'b0) begin n_fail++; $display("FAIL rmid_async_req: got %b want 0", m_req); end
    b_rd_i = 0;
    drain(3);
    rst_n = 1'b1;
    drain(3);
    n_chk++; if (dvi_n !== 0 || dv_n !== 0 || m_req !== 1'b0) begin n_fail++; $display("FAIL rmid_no_dv: got i=%0d d=%0d req=%b want 0 0 0", dvi_n, dv_n, m_req); end
    n_chk++; if (b_data_i !== '0) begin n_fail++; $display("FAIL rmid_line_cleared: got %h want 0", b_data_i[63:0]); end
    clr_mon;
    b_rd_i = 1;
    serve(100, 64'h6000, 1, 0, 100);
    n_chk++; if (dvi_cyc !== 17) begin n_fail++; $display("FAIL rmid_after_latency: got %0d want 17", dvi_cyc); end
    check_read_line("rmid_after_data", cap_i, 64'h6000);
    drain(3);
  endtask

  task automatic test_drop_mid;
    clr_mon;
    b_addr_i = 64'h300; b_rd_i = 1;
    serve(100, 64'h7000, 1, 5, 100);
    b_rd_i = 0;
    serve(100, 64'h7000, 1, 0, 100);
    drain(4);
    n_chk++; if (dvi_n !== 1 || dv_n !== 0) begin n_fail++; $display("FAIL drop_dv_count: got i=%0d d=%0d want i=1 d=0", dvi_n, dv_n); end
    n_chk++; if (dvi_cyc !== 17) begin n_fail++; $display("FAIL drop_latency: got %0d want 17", dvi_cyc); end
    check_read_line("drop_data", cap_i, 64'h7000);
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    test_reset;
    test_i_read;
    test_d_write(1'b0, 70);
    test_round_robin;
    test_random_ack;
    test_reset_mid;
    test_d_write(1'b1, 100);
    test_drop_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
